// File: rtl/demux_seq_pkg.sv
// Shared definitions for the demux frame sequencer: FSM state encodings and
// the fixed field widths of the serial frame.
package demux_seq_pkg;

    localparam int ADDR_BITS = 3;
    localparam int COUNT_W   = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_ADDR    = 3'd1;
    localparam state_t ST_DATA    = 3'd2;
    localparam state_t ST_STOP    = 3'd3;
    localparam state_t ST_RECOVER = 3'd4;

endpackage

// File: rtl/demux_frame_sequencer.sv
// Deframes a serial stream (start, 3-bit address, payload, stop) into a
// registered channel select S and a payload bit I for a 1:8 demultiplexer.
module demux_frame_sequencer
    import demux_seq_pkg::*;
#(
    parameter int DATA_BITS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx_in,
    output logic [2:0]         S,
    output logic               I,
    output logic               frame_active,
    output logic               frame_done,
    output logic               frame_err,
    output logic [COUNT_W-1:0] frame_count
);

    localparam int CNT_W = $clog2((DATA_BITS > ADDR_BITS) ? DATA_BITS : ADDR_BITS);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BITS - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);

    state_t                 state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [ADDR_BITS-1:0]   addr_shift;
    logic [ADDR_BITS-1:0]   addr_next;

    assign addr_next = {addr_shift[ADDR_BITS-2:0], rx_in};

    // S is only ever loaded on the last address edge so it survives errors
    // and idle gaps; I is cleared at the stop edge so the demux idles low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            addr_shift   <= '0;
            S            <= '0;
            I            <= 1'b0;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
            frame_count  <= '0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_in) begin
                        state   <= ST_ADDR;
                        bit_cnt <= '0;
                    end
                end
                ST_ADDR: begin
                    addr_shift <= addr_next;
                    if (bit_cnt == ADDR_LAST) begin
                        S       <= addr_next;
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    I            <= rx_in;
                    frame_active <= 1'b1;
                    if (bit_cnt == DATA_LAST) begin
                        state   <= ST_STOP;
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    I            <= 1'b0;
                    frame_active <= 1'b0;
                    if (rx_in) begin
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        frame_err <= 1'b1;
                        state     <= ST_RECOVER;
                    end
                end
                ST_RECOVER: begin
                    if (rx_in) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux_frame_sequencer.sv
// Directed self-checking bench for demux_frame_sequencer (DATA_BITS=4) with
// hand-computed expected values per clock edge.
module tb_demux_frame_sequencer;
    import demux_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_in;
    logic [2:0] S;
    logic       I;
    logic       frame_active;
    logic       frame_done;
    logic       frame_err;
    logic [7:0] frame_count;

    int checks   = 0;
    int failures = 0;

    demux_frame_sequencer #(.DATA_BITS(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_in        (rx_in),
        .S            (S),
        .I            (I),
        .frame_active (frame_active),
        .frame_done   (frame_done),
        .frame_err    (frame_err),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one serial bit, let it be sampled, then settle 1 time unit past the edge.
    task automatic apply_stimulus(input logic b);
        rx_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic step_check(input string tag, input logic b, input logic [2:0] es,
                              input logic ei, input logic ea, input logic ed,
                              input logic ee, input logic [7:0] ec);
        logic [7:0] demux_act;
        logic [7:0] demux_exp;
        apply_stimulus(b);
        demux_act = I ? (8'b1 << S) : 8'h00;
        demux_exp = ei ? (8'b1 << es) : 8'h00;
        check_output({tag, ".S"}, 32'(S), 32'(es));
        check_output({tag, ".I"}, 32'(I), 32'(ei));
        check_output({tag, ".active"}, 32'(frame_active), 32'(ea));
        check_output({tag, ".done"}, 32'(frame_done), 32'(ed));
        check_output({tag, ".err"}, 32'(frame_err), 32'(ee));
        check_output({tag, ".count"}, 32'(frame_count), 32'(ec));
        check_output({tag, ".demux"}, 32'(demux_act), 32'(demux_exp));
    endtask

    task automatic send_frame(input logic [2:0] a, input logic [3:0] d, input logic stop);
        apply_stimulus(1'b0);
        for (int k = 2; k >= 0; k--) apply_stimulus(a[k]);
        for (int k = 3; k >= 0; k--) apply_stimulus(d[k]);
        apply_stimulus(stop);
    endtask

    task automatic do_reset();
        rx_in = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rx_in = 1'b1;
        rst_n = 1'b0;
        #1;
        check_output("async_reset.S", 32'(S), 32'd0);
        do_reset();
        repeat (10) apply_stimulus(1'b1);
        check_output("idle.S", 32'(S), 32'd0);
        check_output("idle.I", 32'(I), 32'd0);
        check_output("idle.active", 32'(frame_active), 32'd0);
        check_output("idle.done", 32'(frame_done), 32'd0);
        check_output("idle.err", 32'(frame_err), 32'd0);
        check_output("idle.count", 32'(frame_count), 32'd0);
        check_output("idle.state", 32'(dut.state), 32'(ST_IDLE));

        // Good frame: address 5, payload 1011
        step_check("good1", 1'b0, 3'd0, 0, 0, 0, 0, 8'd0);
        step_check("good2", 1'b1, 3'd0, 0, 0, 0, 0, 8'd0);
        step_check("good3", 1'b0, 3'd0, 0, 0, 0, 0, 8'd0);
        step_check("good4", 1'b1, 3'd5, 0, 0, 0, 0, 8'd0);
        step_check("good5", 1'b1, 3'd5, 1, 1, 0, 0, 8'd0);
        step_check("good6", 1'b0, 3'd5, 0, 1, 0, 0, 8'd0);
        step_check("good7", 1'b1, 3'd5, 1, 1, 0, 0, 8'd0);
        step_check("good8", 1'b1, 3'd5, 1, 1, 0, 0, 8'd0);
        step_check("good9", 1'b1, 3'd5, 0, 0, 1, 0, 8'd1);
        step_check("good10", 1'b1, 3'd5, 0, 0, 0, 0, 8'd1);

        // Bad stop: address 3, payload 1111, stop bit 0
        do_reset();
        step_check("bad1", 1'b0, 3'd0, 0, 0, 0, 0, 8'd0);
        step_check("bad2", 1'b0, 3'd0, 0, 0, 0, 0, 8'd0);
        step_check("bad3", 1'b1, 3'd0, 0, 0, 0, 0, 8'd0);
        step_check("bad4", 1'b1, 3'd3, 0, 0, 0, 0, 8'd0);
        step_check("bad5", 1'b1, 3'd3, 1, 1, 0, 0, 8'd0);
        step_check("bad6", 1'b1, 3'd3, 1, 1, 0, 0, 8'd0);
        step_check("bad7", 1'b1, 3'd3, 1, 1, 0, 0, 8'd0);
        step_check("bad8", 1'b1, 3'd3, 1, 1, 0, 0, 8'd0);
        step_check("bad9", 1'b0, 3'd3, 0, 0, 0, 1, 8'd0);
        step_check("bad10", 1'b0, 3'd3, 0, 0, 0, 0, 8'd0);
        check_output("bad10.state", 32'(dut.state), 32'(ST_RECOVER));
        step_check("bad11", 1'b1, 3'd3, 0, 0, 0, 0, 8'd0);
        check_output("bad11.state", 32'(dut.state), 32'(ST_IDLE));
        step_check("bad12", 1'b1, 3'd3, 0, 0, 0, 0, 8'd0);
        check_output("bad12.state", 32'(dut.state), 32'(ST_IDLE));

        // Back-to-back: address 7 payload 1111, then address 0 payload 0101, no gap
        do_reset();
        send_frame(3'd7, 4'b1111, 1'b1);
        check_output("b2b1.S", 32'(S), 32'd7);
        check_output("b2b1.done", 32'(frame_done), 32'd1);
        check_output("b2b1.count", 32'(frame_count), 32'd1);
        step_check("b2b_start", 1'b0, 3'd7, 0, 0, 0, 0, 8'd1);
        step_check("b2b_a2", 1'b0, 3'd7, 0, 0, 0, 0, 8'd1);
        step_check("b2b_a1", 1'b0, 3'd7, 0, 0, 0, 0, 8'd1);
        step_check("b2b_a0", 1'b0, 3'd0, 0, 0, 0, 0, 8'd1);
        step_check("b2b_d3", 1'b0, 3'd0, 0, 1, 0, 0, 8'd1);
        step_check("b2b_d2", 1'b1, 3'd0, 1, 1, 0, 0, 8'd1);
        step_check("b2b_d1", 1'b0, 3'd0, 0, 1, 0, 0, 8'd1);
        step_check("b2b_d0", 1'b1, 3'd0, 1, 1, 0, 0, 8'd1);
        step_check("b2b_stop", 1'b1, 3'd0, 0, 0, 1, 0, 8'd2);

        // Reset asserted during the second payload bit
        do_reset();
        apply_stimulus(1'b0);
        apply_stimulus(1'b1);
        apply_stimulus(1'b0);
        apply_stimulus(1'b1);
        step_check("mid_d1", 1'b1, 3'd5, 1, 1, 0, 0, 8'd0);
        rx_in = 1'b0;
        rst_n = 1'b0;
        #1;
        check_output("mid_rst.S", 32'(S), 32'd0);
        check_output("mid_rst.I", 32'(I), 32'd0);
        check_output("mid_rst.active", 32'(frame_active), 32'd0);
        check_output("mid_rst.state", 32'(dut.state), 32'(ST_IDLE));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) apply_stimulus(1'b1);
        check_output("mid_idle.state", 32'(dut.state), 32'(ST_IDLE));
        check_output("mid_idle.active", 32'(frame_active), 32'd0);
        send_frame(3'd6, 4'b1001, 1'b1);
        check_output("mid_good.S", 32'(S), 32'd6);
        check_output("mid_good.done", 32'(frame_done), 32'd1);
        check_output("mid_good.count", 32'(frame_count), 32'd1);

        // Wrap of the good-frame counter after 256 frames
        do_reset();
        for (int i = 0; i < 256; i++) begin
            send_frame(i[2:0], i[3:0], 1'b1);
            if (i == 0) check_output("wrap.count1", 32'(frame_count), 32'd1);
            if (i == 254) check_output("wrap.count255", 32'(frame_count), 32'd255);
        end
        check_output("wrap.done", 32'(frame_done), 32'd1);
        check_output("wrap.count0", 32'(frame_count), 32'd0);
        check_output("wrap.S", 32'(S), 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
